result_collector: RTL

Downstream consumer of the output FIFO's master port. Accepts processed words over the `mstr0_data` / `mstr0_data_valid` / `mstr0_ready` handshake and groups them into fixed-length frames. Writes each frame into a ping-pong buffer region per source in an external write-only memory. Signals frame completion to the host, along with the frame's source and an optional checksum.

---
 rtl/result_collector_pkg.sv | 17 +
 rtl/result_collector_skid.sv | 30 +++
 rtl/result_collector.sv | 120 ++++++++++++
 3 files changed

// File: rtl/result_collector_pkg.sv
// Shared types and helpers for result_collector: FSM states, checksum width, address packing.
package result_collector_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam int SUM_W = 16;

    // Packs {src, bank, idx}; caller truncates to its address width.
    function automatic logic [31:0] pack_addr(input logic src, input logic bank,
                                              input logic [29:0] idx, input int idx_w);
        return ({31'b0, src} << (idx_w + 1)) | ({31'b0, bank} << idx_w) | {2'b0, idx};
    endfunction

endpackage

// File: rtl/result_collector_skid.sv
// One-entry holding register: word visible on out_* one cycle after acceptance.
// in_rdy follows out_rdy combinationally when full, so a drain and a refill can share a cycle.
module result_collector_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    input  logic         out_rdy
);

    assign in_rdy = rst_n && (!out_vld || out_rdy);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (in_vld && in_rdy) begin
            out_vld <= 1'b1;
            out_dat <= in_dat;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/result_collector.sv
// Frames FIFO words into per-source ping-pong memory regions; write issued 1 cycle after accept,
// frame_done 1 cycle after the last write; mem_ready low stalls mstr0_ready. Option: RESULT_COLLECTOR_CHECKSUM_EN.
module result_collector
    import result_collector_pkg::*;
#(
    parameter int DW          = 32,
    parameter int FRAME_WORDS = 64,
    parameter int IDX_W       = $clog2(FRAME_WORDS),
    parameter int ADDR_W      = IDX_W + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DW-1:0]     mstr0_data,
    input  logic [1:0]        mstr0_data_valid,
    output logic              mstr0_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DW-1:0]     mem_wr_data,
    input  logic              mem_ready,
    output logic              frame_done,
    output logic              frame_src,
    output logic              frame_bank,
    output logic [SUM_W-1:0]  frame_sum,
    output logic              err_src_switch,
    input  logic              clr_err
);

    state_t             state, state_nxt;
    logic               acc, src_in, cur_src, drain, hold_last;
    logic               new_frame, src_sw, last_word;
    logic [1:0]         bank;
    logic [IDX_W-1:0]   nxt_idx, wr_idx;
    logic [ADDR_W-1:0]  wr_addr;

    assign src_in  = mstr0_data_valid[1];
    assign acc     = mstr0_data_valid[0] && mstr0_ready;
    assign drain   = mem_wr_en && mem_ready;
    assign wr_addr = ADDR_W'(pack_addr(src_in, bank[src_in], 30'(wr_idx), IDX_W));

    result_collector_skid #(.W(DW + ADDR_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (mstr0_data_valid[0]),
        .in_dat  ({wr_addr, mstr0_data}),
        .in_rdy  (mstr0_ready),
        .out_vld (mem_wr_en),
        .out_dat ({mem_wr_addr, mem_wr_data}),
        .out_rdy (mem_ready)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc) state_nxt = COLLECT;
            COLLECT: if (last_word) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A source switch restarts at idx 0, so it can never also be the last word (FRAME_WORDS >= 2).
    always_comb begin
        src_sw    = acc && (state == COLLECT) && (src_in != cur_src);
        new_frame = acc && ((state == IDLE) || src_sw);
        wr_idx    = new_frame ? '0 : nxt_idx;
        last_word = acc && (wr_idx == IDX_W'(FRAME_WORDS - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_src        <= 1'b0;
            bank           <= 2'b00;
            nxt_idx        <= '0;
            hold_last      <= 1'b0;
            err_src_switch <= 1'b0;
            frame_done     <= 1'b0;
            frame_src      <= 1'b0;
            frame_bank     <= 1'b0;
        end else begin
            if (acc) begin
                nxt_idx   <= wr_idx + 1'b1;
                hold_last <= last_word;
            end
            if (new_frame) cur_src <= src_in;
            if (last_word) bank[src_in] <= ~bank[src_in];
            err_src_switch <= (err_src_switch && !clr_err) || src_sw;
            frame_done     <= drain && hold_last;
            if (drain && hold_last) begin
                frame_src  <= mem_wr_addr[ADDR_W-1];
                frame_bank <= mem_wr_addr[ADDR_W-2];
            end
        end
    end

`ifdef RESULT_COLLECTOR_CHECKSUM_EN
    logic [SUM_W-1:0] sum_acc, sum_nxt, pend_sum;

    assign sum_nxt = (new_frame ? '0 : sum_acc) + mstr0_data[SUM_W-1:0];

    // pend_sum carries the finished sum until its last word leaves the holding register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_acc   <= '0;
            pend_sum  <= '0;
            frame_sum <= '0;
        end else begin
            if (acc)       sum_acc  <= sum_nxt;
            if (last_word) pend_sum <= sum_nxt;
            if (drain && hold_last) frame_sum <= pend_sum;
        end
    end
`else
    assign frame_sum = '0;
`endif

endmodule
